fifo_banked: RTL and testbench

Parametrised synchronous FIFO built from BANKS equal storage banks that fill in sequence, with full/empty, fill count and programmable almost-full/almost-empty thresholds. It is the general-depth, general-bank-count successor to our two-bank cascaded FIFO. Writes and reads share one global pointer pair; the upper pointer bits select the bank. It sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_bank_ram.sv | 24 ++
 rtl/fifo_banked.sv | 104 ++++++++++
 tb/tb_fifo_banked.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and default geometry for the banked FIFO.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned DEF_BANKS      = 4;
  localparam int unsigned DEF_BANK_DEPTH = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_AW = clog2(DEF_BANKS * DEF_BANK_DEPTH);
  localparam int unsigned DEF_BW = clog2(DEF_BANK_DEPTH);

endpackage

// File: rtl/fifo_bank_ram.sv
// One storage bank: synchronous write port, asynchronous read port.
module fifo_bank_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = 2 ** DEF_BW
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/fifo_banked.sv
// Banked synchronous FIFO: one global pointer pair, upper pointer bits pick the bank.
module fifo_banked
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BANKS      = DEF_BANKS,
  parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [WIDTH-1:0]                      data_in,
  input  logic                                  put,
  input  logic                                  get,
  output logic [WIDTH-1:0]                      data_out,
  output logic [clog2(BANKS*BANK_DEPTH):0]      fillcount,
  output logic                                  empty,
  output logic                                  full,
  output logic                                  almost_full,
  output logic                                  almost_empty,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int unsigned DEPTH = BANKS * BANK_DEPTH;
  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned BW    = clog2(BANK_DEPTH);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_V  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_V    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_V    = (AW+1)'(AE_THRESH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [WIDTH-1:0]  r_data_out;
  logic              r_overflow;
  logic              r_underflow;

  logic [AW:0]       w_fill;
  logic              w_empty;
  logic              w_full;
  logic              w_put_ok;
  logic              w_get_ok;
  logic [BANKS-1:0]  w_we;
  logic [WIDTH-1:0]  w_bank_rdata [BANKS];
  logic [WIDTH-1:0]  w_rdata;

  assign w_fill   = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_fill == '0);
  assign w_full   = (w_fill == FULL_V);
  assign w_put_ok = put && !w_full;
  assign w_get_ok = get && !w_empty;

  always_comb begin
    w_we = '0;
    if (w_put_ok) w_we[r_wr_ptr[AW-1:BW]] = 1'b1;
  end

  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    fifo_bank_ram #(
      .WIDTH (WIDTH),
      .DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (w_we[g]),
      .waddr (r_wr_ptr[BW-1:0]),
      .wdata (data_in),
      .raddr (r_rd_ptr[BW-1:0]),
      .rdata (w_bank_rdata[g])
    );
  end

  assign w_rdata = w_bank_rdata[r_rd_ptr[AW-1:BW]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_data_out  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= put && w_full;
      r_underflow <= get && w_empty;
      if (w_put_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_get_ok) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= w_rdata;
      end
    end
  end

  assign data_out     = r_data_out;
  assign fillcount    = w_fill;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (w_fill >= AF_V);
  assign almost_empty = (w_fill <= AE_V);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_banked.sv
// Directed self-checking bench for fifo_banked (default and 8x2 geometries).
module tb_fifo_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        put = 1'b0, get = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic [4:0]  fill;
  logic        empty, full, af, ae, ovf, udf;

  logic        put_b = 1'b0, get_b = 1'b0;
  logic [7:0]  din_b = '0;
  logic [7:0]  dout_b;
  logic [4:0]  fill_b;
  logic        empty_b, full_b, af_b, ae_b, ovf_b, udf_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_banked dut (
    .clk(clk), .reset(rst), .data_in(din), .put(put), .get(get),
    .data_out(dout), .fillcount(fill), .empty(empty), .full(full),
    .almost_full(af), .almost_empty(ae), .overflow(ovf), .underflow(udf)
  );

  fifo_banked #(
    .WIDTH(8), .BANKS(8), .BANK_DEPTH(2), .AF_THRESH(15), .AE_THRESH(0)
  ) dut_b (
    .clk(clk), .reset(rst), .data_in(din_b), .put(put_b), .get(get_b),
    .data_out(dout_b), .fillcount(fill_b), .empty(empty_b), .full(full_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (fill !== 5'd0)   begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (ae !== 1'b1)     begin errors++; $display("FAIL reset_ae: got %b expected 1", ae); end
    checks++; if (af !== 1'b0)     begin errors++; $display("FAIL reset_af: got %b expected 0", af); end
    checks++; if (dout !== 16'h0)  begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ovf=%b udf=%b expected 0 0", ovf, udf); end
    checks++; if (fill_b !== 5'd0 || ae_b !== 1'b1) begin errors++; $display("FAIL reset_b: got fill=%0d ae=%b expected 0 1", fill_b, ae_b); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      put = 1'b1; din = 16'(i);
      tick();
      checks++; if (fill !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fill, i); end
      checks++; if (full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, i == 16); end
      checks++; if (af !== (i >= 12)) begin errors++; $display("FAIL fill_af[%0d]: got %b expected %b", i, af, i >= 12); end
      checks++; if (ae !== (i <= 2)) begin errors++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, ae, i <= 2); end
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
    end
    din = 16'h0099;
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", ovf); end
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL ovf_fill: got %0d expected 16", fill); end
    put = 1'b0;
    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      get = 1'b1;
      tick();
      checks++; if (dout !== 16'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, dout, 16'(i)); end
      checks++; if (fill !== 5'(16 - i)) begin errors++; $display("FAIL drain_fill[%0d]: got %0d expected %0d", i, fill, 16 - i); end
      checks++; if (empty !== (i == 16)) begin errors++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, empty, i == 16); end
    end
    tick();
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_pulse: got %b expected 1", udf); end
    checks++; if (dout !== 16'h0010) begin errors++; $display("FAIL udf_hold: got %h expected 0010", dout); end
    get = 1'b0;
    tick();
    checks++; if (udf !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", udf); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      put = 1'b1; din = 16'(16'h0100 + k);
      tick();
    end
    for (int n = 0; n < 40; n++) begin
      put = 1'b1; get = 1'b1; din = 16'(16'h0105 + n);
      tick();
      checks++; if (fill !== 5'd5) begin errors++; $display("FAIL stream_fill[%0d]: got %0d expected 5", n, fill); end
      checks++; if (dout !== 16'(16'h0100 + n)) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", n, dout, 16'(16'h0100 + n)); end
    end
    put = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++; if (dout !== 16'(16'h0128 + j)) begin errors++; $display("FAIL stream_tail[%0d]: got %h expected %h", j, dout, 16'(16'h0128 + j)); end
    end
    get = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %b expected 1", empty); end
  endtask

  task automatic test_simultaneous();
    put = 1'b1; get = 1'b1; din = 16'hAAAA;
    tick();
    checks++; if (fill !== 5'd1) begin errors++; $display("FAIL simul_empty_fill: got %0d expected 1", fill); end
    checks++; if (udf !== 1'b1) begin errors++; $display("FAIL simul_empty_udf: got %b expected 1", udf); end
    checks++; if (dout !== 16'h012C) begin errors++; $display("FAIL simul_empty_dout: got %h expected 012C", dout); end
    get = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      din = 16'(16'h0200 + k);
      tick();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL simul_full_pre: got %b expected 1", full); end
    get = 1'b1; din = 16'h5555;
    tick();
    checks++; if (fill !== 5'd15) begin errors++; $display("FAIL simul_full_fill: got %0d expected 15", fill); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL simul_full_ovf: got %b expected 1", ovf); end
    checks++; if (dout !== 16'hAAAA) begin errors++; $display("FAIL simul_full_dout: got %h expected AAAA", dout); end
    put = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++; if (dout !== 16'(16'h0200 + k)) begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", k, dout, 16'(16'h0200 + k)); end
    end
    get = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty_end: got %b expected 1", empty); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 7; k++) begin
      put = 1'b1; din = 16'(16'h0300 + k);
      tick();
    end
    checks++; if (fill !== 5'd7) begin errors++; $display("FAIL arst_pre_fill: got %0d expected 7", fill); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fill !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL arst_fill: got fill=%0d empty=%b expected 0 1", fill, empty); end
    checks++; if (ae !== 1'b1 || af !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL arst_flags: got ae=%b af=%b full=%b expected 1 0 0", ae, af, full); end
    checks++; if (dout !== 16'h0) begin errors++; $display("FAIL arst_dout: got %h expected 0000", dout); end
    put = 1'b0;
    #1;
    rst = 1'b0;
    put = 1'b1; din = 16'hBEEF;
    tick();
    put = 1'b0; get = 1'b1;
    tick();
    get = 1'b0;
    checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL arst_beef: got %h expected BEEF", dout); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL arst_after_fill: got %0d expected 0", fill); end
  endtask

  task automatic test_small_config();
    for (int i = 1; i <= 15; i++) begin
      put_b = 1'b1; din_b = 8'(i);
      tick();
      checks++; if (fill_b !== 5'(i)) begin errors++; $display("FAIL b_fill[%0d]: got %0d expected %0d", i, fill_b, i); end
      checks++; if (af_b !== (i >= 15)) begin errors++; $display("FAIL b_af[%0d]: got %b expected %b", i, af_b, i >= 15); end
      checks++; if (full_b !== 1'b0 || ae_b !== 1'b0) begin errors++; $display("FAIL b_full_ae[%0d]: got full=%b ae=%b expected 0 0", i, full_b, ae_b); end
    end
    put_b = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      get_b = 1'b1;
      tick();
      checks++; if (dout_b !== 8'(j)) begin errors++; $display("FAIL b_data[%0d]: got %h expected %h", j, dout_b, 8'(j)); end
      checks++; if (ae_b !== (j == 15)) begin errors++; $display("FAIL b_ae[%0d]: got %b expected %b", j, ae_b, j == 15); end
      checks++; if (af_b !== 1'b0) begin errors++; $display("FAIL b_af_drain[%0d]: got %b expected 0", j, af_b); end
    end
    get_b = 1'b0;
    tick();
    checks++; if (empty_b !== 1'b1 || fill_b !== 5'd0) begin errors++; $display("FAIL b_empty: got empty=%b fill=%0d expected 1 0", empty_b, fill_b); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simultaneous();
    test_async_reset();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
